// File: rtl/pattern_arb_pkg.sv
// pattern_arb_pkg
//   Shared definitions for the pattern arbiter and the LFSR it drives:
//   FSM state encoding, LFSR seed and feedback taps, default settling delay,
//   and the LFSR next-state function (also used by the lane checkers).
package pattern_arb_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BURST   = 2'd2,
        ST_GAP     = 2'd3
    } arb_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hABCD;

    localparam int LFSR_TAP_A = 12;
    localparam int LFSR_TAP_B = 3;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    localparam int STARTUP_CYCLES_DEF = 24;

    // Right shift; the new MSB is the XNOR of the four taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = ~(s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]);
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/pattern_arbiter_if.sv
// pattern_arbiter_if
//   Request / stream bundle between the pattern arbiter and its consumers.
//   master : arbiter side (drives grant, out_valid, out_data, out_last, busy)
//   slave  : consumer side (drives req, burst_len, rdy)
interface pattern_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_SIZE   = 4,
    parameter int BURST_LEN_W = 8
);
    logic [NUM_REQ-1:0]     req;
    logic [BURST_LEN_W-1:0] burst_len;
    logic [NUM_REQ-1:0]     rdy;
    logic [NUM_REQ-1:0]     grant;
    logic                   out_valid;
    logic [DATA_SIZE-1:0]   out_data;
    logic                   out_last;
    logic                   busy;

    modport master (
        input  req, burst_len, rdy,
        output grant, out_valid, out_data, out_last, busy
    );

    modport slave (
        output req, burst_len, rdy,
        input  grant, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/pattern_lfsr.sv
// pattern_lfsr
//   16-bit Fibonacci LFSR, seeded with LFSR_SEED at reset.
//   clk, rstn : clock, async active-low reset
//   load      : reload the seed (wins over step)
//   step      : advance one position
//   state     : current LFSR contents
module pattern_lfsr
    import pattern_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= LFSR_SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/pattern_arbiter.sv
// pattern_arbiter
//   Shares one LFSR pattern source among NUM_REQ consumers. After a settling
//   delay, requesters are granted fixed-length bursts round-robin on a
//   valid/ready stream.
//   clk, rstn : clock, async active-low reset
//   bus       : pattern_arbiter_if.master (req, burst_len, rdy in;
//               grant, out_valid, out_data, out_last, busy out)
//   Build option: PATTERN_ARB_RESEED_EN reloads the LFSR seed at the start of
//   every burst so each burst sees the same sequence.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_STARTUP | settling delay after reset, requests ignored
//   ST_IDLE    | waiting for any request, arbitrates round-robin
//   ST_BURST   | streaming beats to the granted requester
//   ST_GAP     | one dead cycle after the last beat, grant released
module pattern_arbiter
    import pattern_arb_pkg::*;
#(
    parameter int DATA_SIZE      = 4,
    parameter int NUM_REQ        = 4,
    parameter int BURST_LEN_W    = 8,
    parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    pattern_arbiter_if.master   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SU_W  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    arb_state_t             state, state_nxt;
    logic [SU_W-1:0]        su_cnt;
    logic [BURST_LEN_W-1:0] beat_cnt;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic                   win_found;
    logic                   xfer;
    logic                   last_beat;
    logic                   start_burst;
    logic                   lfsr_load;
    logic [15:0]            lfsr_state;
    logic                   lfsr_unused;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign xfer        = (state == ST_BURST) && bus.rdy[gnt_idx];
    assign last_beat   = (beat_cnt == BURST_LEN_W'(1));
    assign start_burst = (state == ST_IDLE) && win_found;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            ST_STARTUP: begin
                if (su_cnt == '0) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (win_found) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                bus.out_valid = 1'b1;
                bus.out_last  = last_beat;
                if (xfer && last_beat) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_STARTUP;
        endcase
    end

    // Datapath: settling timer, beat counter, grant and round-robin pointer.
    // beat_cnt loaded with 0 wraps through all 2^BURST_LEN_W values before
    // reaching 1, giving the full-length burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            su_cnt   <= SU_W'(STARTUP_CYCLES - 1);
            beat_cnt <= '0;
            grant_q  <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
        end else begin
            if (state == ST_STARTUP && su_cnt != '0) begin
                su_cnt <= su_cnt - SU_W'(1);
            end
            if (start_burst) begin
                beat_cnt <= bus.burst_len;
                grant_q  <= NUM_REQ'(1) << win_idx;
                gnt_idx  <= win_idx;
                rr_ptr   <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
            end else if (xfer) begin
                beat_cnt <= beat_cnt - BURST_LEN_W'(1);
                if (last_beat) grant_q <= '0;
            end
        end
    end

`ifdef PATTERN_ARB_RESEED_EN
    assign lfsr_load = start_burst;
`else
    assign lfsr_load = 1'b0;
`endif

    pattern_lfsr u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .load  (lfsr_load),
        .step  (xfer),
        .state (lfsr_state)
    );

    // Only the low bits leave the block; the rest is kept for the sequence.
    assign lfsr_unused  = ^lfsr_state;
    assign bus.grant    = grant_q;
    assign bus.out_data = lfsr_state[DATA_SIZE-1:0];

endmodule

// File: tb/tb_pattern_arbiter.sv
// tb_pattern_arbiter
//   Scoreboard bench for pattern_arbiter: expected beats are pushed when a
//   burst is set up and popped on every observed transfer.
module tb_pattern_arbiter;
    import pattern_arb_pkg::*;

    localparam logic [15:0] SEED = 16'hABCD;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] data;
        logic       last;
    } beat_t;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;
    beat_t sb_q[$];
    logic [15:0] mdl;

    pattern_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(4), .BURST_LEN_W(8)) bus ();

    pattern_arbiter #(
        .DATA_SIZE(4), .NUM_REQ(4), .BURST_LEN_W(8), .STARTUP_CYCLES(24)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mdl_step(input logic [15:0] s);
        logic nb;
        nb = ~(s[12] ^ s[3] ^ s[1] ^ s[0]);
        return {nb, s[15:1]};
    endfunction

    task automatic push_burst(input int idx, input int len);
        int n;
        beat_t b;
        n = (len == 0) ? 256 : len;
`ifdef PATTERN_ARB_RESEED_EN
        mdl = SEED;
`endif
        for (int i = 0; i < n; i++) begin
            b.grant = 4'(1 << idx);
            b.data  = mdl[3:0];
            b.last  = (i == n - 1);
            sb_q.push_back(b);
            mdl = mdl_step(mdl);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && bus.out_valid && ((bus.grant & bus.rdy) != 4'b0)) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_beat", 32'd1, 32'd0);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("sb_grant", 32'(bus.grant), 32'(e.grant));
                chk("sb_data", 32'(bus.out_data), 32'(e.data));
                chk("sb_last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic want, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid == want) break;
            tick();
        end
        chk(tag, 32'(bus.out_valid), 32'(want));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic start_reset();
        rstn = 1'b0;
        #3;
        sb_q.delete();
        mdl = SEED;
    endtask

    // Releases reset at a falling edge and returns the cycle of the first grant.
    task automatic release_and_time_grant(output int first);
        @(negedge clk);
        rstn  = 1'b1;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.grant != 4'b0) begin
                first = c;
                break;
            end
        end
    endtask

    initial begin
        int first;
        logic [3:0] held;
        n_total       = 0;
        n_bad         = 0;
        mdl           = SEED;
        rstn          = 1'b0;
        bus.req       = 4'b0001;
        bus.burst_len = 8'd3;
        bus.rdy       = 4'b1111;

        // Reset values
        #12;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_last", 32'(bus.out_last), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_data", 32'(bus.out_data), 32'hD);

        // Startup gate: first grant on cycle 25, burst D,6,...
        push_burst(0, 3);
        release_and_time_grant(first);
        chk("startup_cycle", 32'(first), 32'd25);
        chk("startup_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        wait_drain(20, "startup_drain");

        // Round-robin with burst_len=2: order 0,1,2,3,0, period 4
        start_reset();
        bus.req       = 4'b1111;
        bus.burst_len = 8'd2;
        for (int b = 0; b < 5; b++) push_burst(b % 4, 2);
        release_and_time_grant(first);
        chk("rr_first_cycle", 32'(first), 32'd25);
        for (int b = 0; b < 5; b++) begin
            chk("rr_grant", 32'(bus.grant), 32'(1 << (b % 4)));
            chk("rr_valid", 32'(bus.out_valid), 32'h1);
            if (b == 4) bus.req = 4'b0000;
            tick();
            chk("rr_last_beat2", 32'(bus.out_last), 32'h1);
            tick();
            chk("rr_gap_grant", 32'(bus.grant), 32'h0);
            chk("rr_gap_valid", 32'(bus.out_valid), 32'h0);
            chk("rr_gap_busy", 32'(bus.busy), 32'h1);
            tick();
            chk("rr_idle_busy", 32'(bus.busy), 32'h0);
            tick();
        end
        chk("rr_quiet_valid", 32'(bus.out_valid), 32'h0);
        chk("rr_quiet_busy", 32'(bus.busy), 32'h0);
        chk("rr_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: 3 stalled cycles mid-burst, 5 beats still delivered
        bus.req       = 4'b0010;
        bus.burst_len = 8'd5;
        push_burst(1, 5);
        wait_valid(1'b1, 10, "bp_start");
        chk("bp_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        tick();
        bus.rdy = 4'b0000;
        held = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_stall_data", 32'(bus.out_data), 32'(held));
            chk("bp_stall_last", 32'(bus.out_last), 32'h0);
        end
        bus.rdy = 4'b1111;
        wait_drain(20, "bp_drain");
        tick();
        tick();
        chk("bp_done_valid", 32'(bus.out_valid), 32'h0);

        // burst_len=0: 256 beats, last only on the final one
        bus.req       = 4'b0100;
        bus.burst_len = 8'd0;
        push_burst(2, 0);
        wait_valid(1'b1, 10, "bl0_start");
        chk("bl0_grant", 32'(bus.grant), 32'h4);
        bus.req = 4'b0000;
        wait_drain(300, "bl0_drain");
        tick();
        tick();
        chk("bl0_done_valid", 32'(bus.out_valid), 32'h0);

        // Two consecutive 3-beat bursts from requester 3 (reseed behaviour)
        bus.req       = 4'b1000;
        bus.burst_len = 8'd3;
        push_burst(3, 3);
        push_burst(3, 3);
        wait_valid(1'b1, 10, "rs_start1");
        wait_valid(1'b0, 10, "rs_gap");
        wait_valid(1'b1, 10, "rs_start2");
        chk("rs_grant2", 32'(bus.grant), 32'h8);
        bus.req = 4'b0000;
        wait_drain(20, "rs_drain");

        // Reset during beat 2, then startup repeats with requester 0 first
        bus.req       = 4'b0010;
        bus.burst_len = 8'd4;
        push_burst(1, 4);
        wait_valid(1'b1, 10, "mr_start");
        tick();
        #2;
        start_reset();
        chk("mr_grant", 32'(bus.grant), 32'h0);
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_last", 32'(bus.out_last), 32'h0);
        chk("mr_data", 32'(bus.out_data), 32'hD);
        bus.req = 4'b1111;
        push_burst(0, 4);
        release_and_time_grant(first);
        chk("mr_startup_cycle", 32'(first), 32'd25);
        chk("mr_grant_prio", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        wait_drain(20, "mr_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_arbiter.md
# pattern_arbiter

Shares one LFSR test-pattern source among NUM_REQ consumers. Each consumer gets a fixed-length burst on a valid/ready stream. Bursts are granted round-robin after a power-up settling delay. The block sits between the pattern source and the per-lane checkers, and replaces the free-running generator wherever more than one consumer needs patterns.

## Interface
Parameters:
- DATA_SIZE, 4: width of out_data, taken from the LFSR low bits.
- NUM_REQ, 4: number of requesters (2..8).
- BURST_LEN_W, 8: width of burst_len.
- STARTUP_CYCLES, 24: cycles after reset release before the first grant.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: reset, asynchronous, active-low.
- req, input, NUM_REQ: per-requester burst request, level-sensitive.
- burst_len, input, BURST_LEN_W: beats per burst, sampled at grant; 0 means 2^BURST_LEN_W beats.
- rdy, input, NUM_REQ: per-requester ready; only the bit of the granted requester is used.
- grant, output, NUM_REQ: one-hot grant, held for the whole burst.
- out_valid, output, 1: beat valid.
- out_data, output, DATA_SIZE: pattern beat, equal to lfsr[DATA_SIZE-1:0].
- out_last, output, 1: final beat of the burst, qualified by out_valid.
- busy, output, 1: high in every state except IDLE.

## Operation
- LFSR: 16 bits, seed 16'hABCD. Shift right; the new MSB is the XNOR of taps 12, 3, 1 and 0.
- The LFSR advances only on a transfer (out_valid && rdy[granted index]).
- FSM states: STARTUP, IDLE, BURST, GAP.
- STARTUP: counts STARTUP_CYCLES clocks after rstn deasserts, then moves to IDLE. Requests are ignored during this state.
- IDLE → BURST, when req != 0:
  - grant is loaded with the round-robin winner.
  - The beat counter is loaded with burst_len.
- Round-robin: search starts at index (last granted + 1) mod NUM_REQ. After reset, index 0 has top priority.
- BURST:
  - out_valid=1.
  - On each transfer, the counter decrements and the LFSR steps.
  - out_last=1 when counter==1.
  - A transfer with out_last moves the FSM to GAP.
- GAP: exactly one cycle with grant=0 and out_valid=0, then IDLE.
- Dropping req mid-burst does not abort the burst; it completes. A requester that deasserts rdy simply stalls the burst.
- If req is still set after GAP, the same requester can win again only if no other requester is pending.

## Timing
- Reset values: grant=0, out_valid=0, out_last=0, busy=1 (STARTUP), out_data=4'hD (seed low bits). FSM is in STARTUP, RR pointer is at index 0.
- Earliest grant: cycle STARTUP_CYCLES+1 after the first clk edge with rstn high.
- Latency from req to first valid beat: 1 clk from IDLE.
- Burst cost: N beats occupy N cycles at full rdy, plus 1 GAP cycle, plus 1 IDLE cycle. This gives a back-to-back request period of N+2.
- out_valid stays high while rdy is low, and out_data is held stable.
- Asserting rstn mid-burst:
  - All outputs go to reset values immediately.
  - STARTUP restarts.
  - The RR pointer returns to 0.
- A req arriving in the same cycle as the last transfer is evaluated in the next IDLE.

## Configuration
- PATTERN_ARB_RESEED_EN defined: the LFSR reloads 16'hABCD on every IDLE→BURST transition. Every burst, for every requester, starts with the identical sequence D, 6, ...
- Not defined: the LFSR is loaded only at reset and continues across bursts. Consecutive bursts get disjoint segments of the sequence.

## Structure
- Shared package pattern_arb_pkg contains:
  - FSM state enum.
  - LFSR_SEED = 16'hABCD.
  - Tap positions.
  - Default STARTUP_CYCLES.
- Sub-module pattern_lfsr: 16-bit LFSR with inputs load and step, and output state. It is reused later by the checkers.
- Round-robin arbiter and FSM stay in pattern_arbiter.

## Test plan
- Startup gate: req=4'b0001 held from reset release → grant stays 0 for 24 cycles; grant=4'b0001 on cycle 25; first out_data=4'hD, second 4'h6.
- Round-robin: req=4'b1111, burst_len=2, rdy all 1 → grant order 0,1,2,3,0. Each burst has 2 valid beats, 1 GAP and 1 IDLE cycle; out_last on beat 2.
- Backpressure: rdy[granted]=0 for 3 cycles mid-burst → out_valid stays 1, and out_data and counter are frozen. The burst still delivers exactly burst_len beats.
- burst_len=0 → exactly 256 transfers, out_last only on the 256th.
- Reseed macro: two consecutive bursts of 3 beats → with PATTERN_ARB_RESEED_EN, both give D,6,…; without it, the second burst continues the sequence.
- Reset mid-burst: rstn low during beat 2 → grant, out_valid and out_last go to 0 asynchronously, out_data=4'hD. After release, the 24-cycle STARTUP repeats and requester 0 has priority.
